// File: rtl/fb_pixel_writer.sv
// Write-direction framebuffer engine: buffers an RGB565 pixel stream in a FIFO and
// writes it to SDRAM as fixed-length Avalon-MM bursts, with a small CSR slave.
module fb_pixel_writer #(
    parameter int unsigned BURST_LEN   = 32,
    parameter int unsigned FIFO_DEPTH  = 64,
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned CNT_W       = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_sof,
    output logic [25:0] m_address,
    output logic        m_write_n,
    output logic [15:0] m_writedata,
    output logic [1:0]  m_byteenable_n,
    output logic        m_chipselect,
    input  logic        m_waitrequest,
    input  logic [1:0]  s_address,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata
);

    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned LW     = $clog2(BURST_LEN) + 1;
    localparam int unsigned ADDR_W = 26;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t              state;
    logic [15:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic [ADDR_W-1:0]   pending_base;
    logic [ADDR_W-1:0]   active_base;
    logic [CNT_W-1:0]    word_in;
    logic [CNT_W-1:0]    word_out;
    logic [15:0]         frame_count;
    logic                drop;
    logic                in_frame;
    logic [LW-1:0]       burst_len;
    logic [LW-1:0]       beat;

    logic fifo_empty;
    logic fifo_full;
    logic hold;
    logic accept;
    logic push;
    logic pop;
    logic discard;
    logic flush;
    logic busy;
    logic csr0_wr;
    logic drop_clr;
    logic unused_wdata;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign busy       = (state != IDLE) | !fifo_empty;

    // A start-of-frame waits until the previous frame has completely left the FIFO.
    assign hold     = in_valid & in_sof & busy;
    assign in_ready = !rst & !fifo_full & !hold;
    assign accept   = in_valid & in_ready;
    assign push     = accept & (in_sof | in_frame);
    assign discard  = accept & !in_sof & !in_frame;
    assign pop      = (state == WRITE) & !m_write_n & !m_waitrequest;

    assign flush = (count >= (AW+1)'(BURST_LEN))
                 | (!fifo_empty & !in_frame)
                 | (!fifo_empty & in_valid & in_sof);

    assign m_writedata    = mem[rd_ptr];
    assign m_address      = active_base + ADDR_W'({word_out, 1'b0});
    assign m_byteenable_n = 2'b00;

    assign csr0_wr      = s_write & (s_address == 2'd0);
    assign drop_clr     = s_write & (s_address == 2'd2) & s_writedata[2];
    assign unused_wdata = ^{s_writedata[31:26], s_writedata[0]};

    // FIFO storage; no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame tracking on the input side.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_base <= '0;
            word_in     <= '0;
            in_frame    <= 1'b0;
        end else if (accept & in_sof) begin
            active_base <= pending_base;
            word_in     <= CNT_W'(1);
            in_frame    <= (CNT_W'(FRAME_WORDS) != CNT_W'(1));
        end else if (push) begin
            word_in <= word_in + CNT_W'(1);
            if (word_in + CNT_W'(1) == CNT_W'(FRAME_WORDS)) begin
                in_frame <= 1'b0;
            end
        end
    end

    // CSR registers; a discard in the same cycle as a W1C clear keeps drop set.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_base <= '0;
            drop         <= 1'b0;
        end else begin
            if (csr0_wr) begin
                pending_base <= {s_writedata[25:1], 1'b0};
            end
            if (discard) begin
                drop <= 1'b1;
            end else if (drop_clr) begin
                drop <= 1'b0;
            end
        end
    end

    always_comb begin
        s_readdata = '0;
        case (s_address)
            2'd0:    s_readdata = 32'(pending_base);
            2'd1:    s_readdata = 32'(active_base);
            2'd2:    s_readdata = {frame_count, 13'd0, drop, in_frame, busy};
            default: s_readdata = '0;
        endcase
    end

    // Burst engine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            m_write_n    <= 1'b1;
            m_chipselect <= 1'b0;
            burst_len    <= '0;
            beat         <= '0;
            word_out     <= '0;
            frame_count  <= '0;
        end else begin
            if (accept & in_sof) begin
                word_out <= '0;
            end
            case (state)
                IDLE: begin
                    if (flush) begin
                        state        <= WRITE;
                        burst_len    <= (count >= (AW+1)'(BURST_LEN)) ? LW'(BURST_LEN) : LW'(count);
                        beat         <= '0;
                        m_write_n    <= 1'b0;
                        m_chipselect <= 1'b1;
                    end
                end
                WRITE: begin
                    if (pop) begin
                        beat     <= beat + LW'(1);
                        word_out <= word_out + CNT_W'(1);
                        if (beat + LW'(1) == burst_len) begin
                            state        <= DONE;
                            m_write_n    <= 1'b1;
                            m_chipselect <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (word_out == CNT_W'(FRAME_WORDS)) begin
                        frame_count <= frame_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer: stimulus queues expected SDRAM beats and burst
// lengths, a negedge monitor consumes them as the DUT writes.
module tb_fb_pixel_writer;

    localparam int unsigned FW  = 72;
    localparam int unsigned TMO = 150;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sof;
    logic [25:0] m_address;
    logic        m_write_n;
    logic [15:0] m_writedata;
    logic [1:0]  m_byteenable_n;
    logic        m_chipselect;
    logic        m_waitrequest;
    logic [1:0]  s_address;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;

    typedef struct packed {
        logic [25:0] addr;
        logic [15:0] data;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned blen_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    int          acc_cnt = 0;
    int          beat_cnt = 0;
    logic        prev_wn = 1'b1;
    logic [31:0] rd;

    fb_pixel_writer #(
        .BURST_LEN  (32),
        .FIFO_DEPTH (64),
        .FRAME_WORDS(FW),
        .CNT_W      (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_sof        (in_sof),
        .m_address     (m_address),
        .m_write_n     (m_write_n),
        .m_writedata   (m_writedata),
        .m_byteenable_n(m_byteenable_n),
        .m_chipselect  (m_chipselect),
        .m_waitrequest (m_waitrequest),
        .s_address     (s_address),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Monitor: beats complete on the following rising edge when write is low and not stalled.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            beat_cnt = 0;
            prev_wn  = 1'b1;
        end else begin
            if (!m_write_n) begin
                if (m_waitrequest) begin
                    if (exp_q.size() != 0) begin
                        check("stall_addr", 32'(m_address), 32'(exp_q[0].addr));
                        check("stall_data", 32'(m_writedata), 32'(exp_q[0].data));
                    end
                end else if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", m_address, m_writedata);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_addr", 32'(m_address), 32'(e.addr));
                    check("beat_data", 32'(m_writedata), 32'(e.data));
                    beat_cnt++;
                end
            end
            if (m_write_n && !prev_wn) begin
                if (blen_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_burst: beats %0d", beat_cnt);
                end else begin
                    check("burst_len", 32'(beat_cnt), 32'(blen_q.pop_front()));
                end
                beat_cnt = 0;
            end
            prev_wn = m_write_n;
        end
    end

    task automatic send_pix(input logic [15:0] d, input logic sof, input logic expect_wr,
                            input logic [25:0] addr);
        int    n   = 0;
        logic  acc = 1'b0;
        logic  rdy;
        beat_t b;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        while (!acc && n < int'(TMO)) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            acc = rdy;
            n++;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (!acc) begin
            n_total++;
            $display("FAIL send_timeout: pixel 0x%0h not accepted, required acceptance", d);
        end else begin
            acc_cnt++;
            if (expect_wr) begin
                b.addr = addr;
                b.data = d;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        s_address   = a;
        s_writedata = d;
        s_write     = 1'b1;
        @(posedge clk);
        #1;
        s_write = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        s_address = a;
        #1;
        d = s_readdata;
    endtask

    task automatic wait_idle();
        int          n = 0;
        logic [31:0] st;
        repeat (2) @(posedge clk);
        #1;
        csr_read(2'd2, st);
        while (st[0] && n < 500) begin
            @(posedge clk);
            #1;
            csr_read(2'd2, st);
            n++;
        end
        if (st[0]) begin
            n_total++;
            $display("FAIL drain_timeout: busy still 1, required 0");
        end
    endtask

    task automatic stall_inject();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_write_n && n < int'(TMO));
        repeat (10) @(posedge clk);
        #1;
        m_waitrequest = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("stall_write_n", 32'(m_write_n), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        m_waitrequest = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_sof        = 1'b0;
        in_data       = '0;
        m_waitrequest = 1'b0;
        s_address     = '0;
        s_write       = 1'b0;
        s_writedata   = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        in_valid = 1'b1;
        in_sof   = 1'b1;
        #1;
        check("ready_in_reset", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst      = 1'b0;
        #1;
        check("rst_write_n", 32'(m_write_n), 32'h1);
        check("rst_chipselect", 32'(m_chipselect), 32'h0);
        check("rst_address", 32'(m_address), 32'h0);
        check("byteenable", 32'(m_byteenable_n), 32'h0);
        check("ready_after_reset", 32'(in_ready), 32'h1);
        for (int a = 0; a < 4; a++) begin
            csr_read(2'(a), rd);
            check("rst_csr", rd, 32'h0);
        end

        // Frame 1: 64 pixels with a 5-cycle stall at beat 10, then the 8-word tail
        csr_write(2'd0, 32'h0010_0000);
        csr_read(2'd0, rd);
        check("csr0_readback", rd, 32'h0010_0000);
        blen_q.push_back(32);
        blen_q.push_back(32);
        blen_q.push_back(8);
        fork
            begin
                for (int i = 0; i < 64; i++)
                    send_pix(16'(i), (i == 0), 1'b1, 26'h010_0000 + 26'(2 * i));
            end
            stall_inject();
        join
        wait_idle();
        csr_read(2'd2, rd);
        check("mid_frame_status", rd, 32'h0000_0002);
        for (int i = 64; i < int'(FW); i++)
            send_pix(16'(i), 1'b0, 1'b1, 26'h010_0000 + 26'(2 * i));
        wait_idle();
        check("f1_exp_empty", 32'(exp_q.size()), 32'h0);
        check("f1_blen_empty", 32'(blen_q.size()), 32'h0);
        csr_read(2'd2, rd);
        check("f1_status", rd, 32'h0001_0000);
        csr_read(2'd1, rd);
        check("f1_active_base", rd, 32'h0010_0000);

        // Frame 2: permanent stall fills the FIFO, then release
        csr_write(2'd0, 32'h0020_0000);
        m_waitrequest = 1'b1;
        acc_cnt = 0;
        blen_q.push_back(32);
        blen_q.push_back(32);
        blen_q.push_back(8);
        fork
            begin
                for (int i = 0; i < int'(FW); i++)
                    send_pix(16'h4000 + 16'(i), (i == 0), 1'b1, 26'h020_0000 + 26'(2 * i));
            end
            begin
                repeat (100) @(posedge clk);
                #1;
                check("accepted_when_full", 32'(acc_cnt), 32'd64);
                check("ready_when_full", 32'(in_ready), 32'h0);
                m_waitrequest = 1'b0;
            end
        join
        wait_idle();
        check("f2_accepted", 32'(acc_cnt), 32'(FW));
        check("f2_exp_empty", 32'(exp_q.size()), 32'h0);
        csr_read(2'd2, rd);
        check("f2_status", rd, 32'h0002_0000);

        // Frame 3 truncated after 5 words by a new sof at a wrapping base
        csr_write(2'd0, 32'h0030_0000);
        blen_q.push_back(5);
        for (int i = 0; i < 5; i++)
            send_pix(16'hA000 + 16'(i), (i == 0), 1'b1, 26'h030_0000 + 26'(2 * i));
        csr_write(2'd0, 32'hFFFF_FFC1);
        csr_read(2'd0, rd);
        check("csr0_mask", rd, 32'h03FF_FFC0);
        csr_read(2'd1, rd);
        check("active_base_held", rd, 32'h0030_0000);
        blen_q.push_back(32);
        blen_q.push_back(32);
        blen_q.push_back(8);
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_data  = 16'hB000;
        @(negedge clk);
        check("sof_hold", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(FW); i++)
            send_pix(16'hB000 + 16'(i), (i == 0), 1'b1, 26'h3FF_FFC0 + 26'(2 * i));
        wait_idle();
        check("f4_exp_empty", 32'(exp_q.size()), 32'h0);
        check("f4_blen_empty", 32'(blen_q.size()), 32'h0);
        csr_read(2'd1, rd);
        check("f4_active_base", rd, 32'h03FF_FFC0);
        csr_read(2'd2, rd);
        check("f4_status", rd, 32'h0003_0000);

        // Out-of-frame pixels are dropped; W1C clear and set-wins
        for (int i = 0; i < 3; i++)
            send_pix(16'hD000 + 16'(i), 1'b0, 1'b0, 26'h0);
        repeat (3) @(posedge clk);
        #1;
        csr_read(2'd2, rd);
        check("drop_set", rd, 32'h0003_0004);
        csr_write(2'd2, 32'h0000_0004);
        csr_read(2'd2, rd);
        check("drop_clear", rd, 32'h0003_0000);
        fork
            csr_write(2'd2, 32'h0000_0004);
            send_pix(16'hD100, 1'b0, 1'b0, 26'h0);
        join
        csr_read(2'd2, rd);
        check("drop_set_wins", rd, 32'h0003_0004);
        csr_write(2'd3, 32'hFFFF_FFFF);
        csr_read(2'd3, rd);
        check("csr3_zero", rd, 32'h0);
        csr_read(2'd0, rd);
        check("csr3_no_side_effect", rd, 32'h03FF_FFC0);

        // Reset in the middle of a stalled burst
        csr_write(2'd0, 32'h0000_0100);
        m_waitrequest = 1'b1;
        for (int i = 0; i < 40; i++)
            send_pix(16'hE000 + 16'(i), (i == 0), 1'b0, 26'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_burst_write_n", 32'(m_write_n), 32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_data  = 16'hEEEE;
        #1;
        check("ready_gated_by_rst", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        check("rst_mid_write_n", 32'(m_write_n), 32'h1);
        check("rst_mid_chipselect", 32'(m_chipselect), 32'h0);
        check("rst_mid_address", 32'(m_address), 32'h0);
        for (int a = 0; a < 3; a++) begin
            csr_read(2'(a), rd);
            check("rst_mid_csr", rd, 32'h0);
        end
        exp_q.delete();
        blen_q.delete();
        rst           = 1'b0;
        in_valid      = 1'b0;
        m_waitrequest = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        csr_read(2'd2, rd);
        check("post_reset_idle", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
